// File: rtl/tx_phy_len_calculation.sv
// Transmit PHY length calculator: turns PSDU length and rate into symbol count, pad bits, airtime and L-SIG LENGTH.
// It divides by repeated subtraction, one comparison per cycle, and uses a start/done handshake.
module tx_phy_len_calculation (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        start,
   input  logic [15:0] psdu_len,
   input  logic [7:0]  pkt_rate,
   output logic        busy,
   output logic        done,
   output logic [14:0] n_ofdm_sym,
   output logic [8:0]  n_pad_bits,
   output logic [16:0] tx_duration_us,
   output logic [11:0] l_sig_len,
   output logic        len_err
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_FINAL, S_DONE} state_t;

   state_t      state;
   logic [15:0] len_q;
   logic [7:0]  rate_q;
   logic [8:0]  ndbps_q;
   logic [19:0] rem;
   logic [14:0] cnt;
   logic [8:0]  ndbps_lut;
   logic [16:0] spoof;

   // Zero marks an unsupported rate code
   always_comb begin
      ndbps_lut = 9'd0;
      if (rate_q[7]) begin
         case (rate_q[3:0])
            4'd0:    ndbps_lut = 9'd26;
            4'd1:    ndbps_lut = 9'd52;
            4'd2:    ndbps_lut = 9'd78;
            4'd3:    ndbps_lut = 9'd104;
            4'd4:    ndbps_lut = 9'd156;
            4'd5:    ndbps_lut = 9'd208;
            4'd6:    ndbps_lut = 9'd234;
            4'd7:    ndbps_lut = 9'd260;
            default: ndbps_lut = 9'd0;
         endcase
      end else begin
         case (rate_q[3:0])
            4'b1011: ndbps_lut = 9'd24;
            4'b1111: ndbps_lut = 9'd36;
            4'b1010: ndbps_lut = 9'd48;
            4'b1110: ndbps_lut = 9'd72;
            4'b1001: ndbps_lut = 9'd96;
            4'b1101: ndbps_lut = 9'd144;
            4'b1000: ndbps_lut = 9'd192;
            4'b1100: ndbps_lut = 9'd216;
            default: ndbps_lut = 9'd0;
         endcase
      end
   end

   assign spoof = 17'd3 * {2'b00, n_ofdm_sym} + 17'd9;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         len_q          <= '0;
         rate_q         <= '0;
         ndbps_q        <= '0;
         rem            <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         n_ofdm_sym     <= '0;
         n_pad_bits     <= '0;
         tx_duration_us <= '0;
         l_sig_len      <= '0;
         len_err        <= 1'b0;
      end else if (enable) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  len_q  <= psdu_len;
                  rate_q <= pkt_rate;
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               // 16 SERVICE bits plus 6 tail bits ride in front of the payload
               rem            <= 20'd22 + {1'b0, len_q, 3'b000};
               cnt            <= 15'd1;
               ndbps_q        <= ndbps_lut;
               len_err        <= 1'b0;
               n_ofdm_sym     <= '0;
               n_pad_bits     <= '0;
               tx_duration_us <= '0;
               l_sig_len      <= '0;
               if (ndbps_lut == 9'd0 || (!rate_q[7] && len_q > 16'd4095)) begin
                  len_err <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               if (rem <= {11'd0, ndbps_q}) begin
                  n_ofdm_sym <= cnt;
                  n_pad_bits <= ndbps_q - rem[8:0];
                  state      <= S_FINAL;
               end else begin
                  rem <= rem - {11'd0, ndbps_q};
                  cnt <= cnt + 15'd1;
               end
            end
            S_FINAL: begin
               if (rate_q[7]) begin
                  tx_duration_us <= {n_ofdm_sym, 2'b00} + 17'd36;
                  if (spoof > 17'd4095) begin
                     len_err   <= 1'b1;
                     l_sig_len <= 12'd4095;
                  end else begin
                     l_sig_len <= spoof[11:0];
                  end
               end else begin
                  tx_duration_us <= {n_ofdm_sym, 2'b00} + 17'd20;
                  l_sig_len      <= len_q[11:0];
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_phy_len_calculation.sv
// Scoreboard bench for tx_phy_len_calculation: a driver queues reference results, and a monitor checks each done pulse against them.
module tb_tx_phy_len_calculation;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        start = 1'b0;
   logic [15:0] psdu_len = '0;
   logic [7:0]  pkt_rate = '0;
   logic        busy, done, len_err;
   logic [14:0] n_ofdm_sym;
   logic [8:0]  n_pad_bits;
   logic [16:0] tx_duration_us;
   logic [11:0] l_sig_len;

   tx_phy_len_calculation dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .psdu_len(psdu_len), .pkt_rate(pkt_rate), .busy(busy), .done(done),
      .n_ofdm_sym(n_ofdm_sym), .n_pad_bits(n_pad_bits),
      .tx_duration_us(tx_duration_us), .l_sig_len(l_sig_len), .len_err(len_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int     sym;
      int     pad;
      int     dur;
      int     lsig;
      int     err;
      int     lat;
      longint due;
   } exp_t;

   exp_t   sb[$];
   longint cyc = 0;
   int     tests = 0;
   int     failures = 0;

   int nonht_code[8] = '{11, 15, 10, 14, 9, 13, 8, 12};
   int nonht_dbps[8] = '{24, 36, 48, 72, 96, 144, 192, 216};
   int ht_dbps[8]    = '{26, 52, 78, 104, 156, 208, 234, 260};

   // Reference: ceiling division of the coded bit count by the bits per symbol
   function automatic exp_t model(input int len, input int rate);
      exp_t e;
      int   n_dbps, bits, spoof;
      bit   ht;
      ht = rate[7];
      n_dbps = 0;
      if (ht) begin
         if ((rate & 15) < 8) n_dbps = ht_dbps[rate & 15];
      end else begin
         for (int i = 0; i < 8; i++)
            if ((rate & 15) == nonht_code[i]) n_dbps = nonht_dbps[i];
      end
      e.due = 0;
      if (n_dbps == 0 || (!ht && len > 4095)) begin
         e.sym = 0; e.pad = 0; e.dur = 0; e.lsig = 0; e.err = 1; e.lat = 2;
         return e;
      end
      bits  = 22 + 8 * len;
      e.sym = (bits + n_dbps - 1) / n_dbps;
      e.pad = e.sym * n_dbps - bits;
      e.lat = e.sym + 3;
      if (ht) begin
         e.dur  = 36 + 4 * e.sym;
         spoof  = 3 * e.sym + 9;
         e.err  = (spoof > 4095) ? 1 : 0;
         e.lsig = (spoof > 4095) ? 4095 : spoof;
      end else begin
         e.dur  = 20 + 4 * e.sym;
         e.err  = 0;
         e.lsig = len;
      end
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc = cyc + 1;
   end

   // Monitor: one scoreboard pop per rising edge of done
   initial begin
      logic done_d;
      exp_t e;
      done_d = 1'b0;
      forever begin
         @(negedge clock);
         if (done && !done_d) begin
            if (sb.size() == 0) begin
               tests++;
               failures++;
               $display("FAIL unexpected_done: done seen at cycle %0d, expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("n_ofdm_sym", n_ofdm_sym, e.sym);
               chk("n_pad_bits", n_pad_bits, e.pad);
               chk("tx_duration_us", tx_duration_us, e.dur);
               chk("l_sig_len", l_sig_len, e.lsig);
               chk("len_err", len_err, e.err);
               chk("busy_at_done", busy, 0);
               chk("done_cycle", cyc, e.due);
            end
         end
         done_d = done;
      end
   end

   task automatic issue(input int len, input int rate, input int stall, input bit expect_it);
      exp_t e;
      e = model(len, rate);
      @(negedge clock);
      start    = 1'b1;
      psdu_len = len[15:0];
      pkt_rate = rate[7:0];
      e.due    = cyc + e.lat + stall;
      if (expect_it) sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 25000 && sb.size() != 0; k++) @(negedge clock);
      if (sb.size() != 0) begin
         tests++;
         failures++;
         $display("FAIL timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_sym"}, n_ofdm_sym, 0);
      chk({tag, "_pad"}, n_pad_bits, 0);
      chk({tag, "_dur"}, tx_duration_us, 0);
      chk({tag, "_lsig"}, l_sig_len, 0);
      chk({tag, "_err"}, len_err, 0);
   endtask

   initial begin
      int len, rate;
      repeat (3) @(negedge clock);
      check_zero("in_reset");
      reset = 1'b0;
      @(negedge clock);
      check_zero("after_reset");

      issue(100, 8'h0B, 0, 1);    wait_empty();
      issue(1500, 8'h87, 0, 1);   wait_empty();
      issue(7, 8'h80, 0, 1);      wait_empty();
      issue(0, 8'h0C, 0, 1);      wait_empty();
      issue(100, 8'h05, 0, 1);    wait_empty();
      issue(4096, 8'h0B, 0, 1);   wait_empty();
      issue(4095, 8'h0B, 0, 1);   wait_empty();
      issue(65535, 8'h80, 0, 1);  wait_empty();

      // Back-to-back: second start lands in the first IDLE cycle after done
      issue(40, 8'h0F, 0, 1);
      while (!done) @(negedge clock);
      issue(41, 8'h81, 0, 1);
      wait_empty();

      // A start during DIV must be ignored
      issue(1500, 8'h87, 0, 1);
      repeat (5) @(negedge clock);
      start = 1'b1; psdu_len = 16'd3; pkt_rate = 8'h0B;
      @(negedge clock);
      start = 1'b0;
      wait_empty();
      repeat (5) @(negedge clock);

      // Enable held low for 10 cycles mid-DIV
      issue(1500, 8'h87, 10, 1);
      repeat (5) @(negedge clock);
      enable = 1'b0;
      repeat (10) @(negedge clock);
      enable = 1'b1;
      wait_empty();

      // Reset in the middle of DIV drops the request
      issue(1500, 8'h87, 0, 0);
      repeat (10) @(negedge clock);
      reset = 1'b1;
      #1;
      check_zero("mid_div_reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      issue(200, 8'h0D, 0, 1);    wait_empty();

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 9) < 8) begin
            if ($urandom_range(0, 1) == 1)
               rate = 128 + $urandom_range(0, 7);
            else
               rate = nonht_code[$urandom_range(0, 7)];
         end else begin
            rate = $urandom_range(0, 255);
         end
         if ($urandom_range(0, 4) == 0)
            len = $urandom_range(4090, 4100);
         else
            len = $urandom_range(0, 2000);
         issue(len, rate, 0, 1);
         wait_empty();
      end

      repeat (10) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/tx_phy_len_calculation.md
# tx_phy_len_calculation

Transmit-side PHY length calculator. Given the PSDU length in bytes and the packet rate for a frame to be sent, it computes:
- the number of data OFDM symbols,
- the pad bit count,
- the total PPDU airtime in µs,
- the L-SIG LENGTH field value.

It uses iterative subtraction with a start/done handshake. It sits between the TX MAC interface and the SIGNAL/HT-SIG builder and data scrambler, and mirrors the receive-side symbol-count logic.

## Interface

Parameters: none.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns block to IDLE
- enable  in  1  when low, FSM and all registers hold
- start  in  1  request pulse; sampled only in IDLE with enable=1
- psdu_len  in  16  PSDU length in bytes
- pkt_rate  in  8  bit[7]=1 HT (bits[3:0]=MCS 0-7); bit[7]=0 non-HT (bits[3:0]=L-SIG RATE code)
- busy  out  1  high from LOAD through FINAL
- done  out  1  one-cycle pulse; results valid from this cycle until next start
- n_ofdm_sym  out  15  data symbol count (max 20166)
- n_pad_bits  out  9  n_ofdm_sym*N_DBPS − (22 + 8*psdu_len)
- tx_duration_us  out  17  PPDU airtime, long GI
- l_sig_len  out  12  L-SIG LENGTH field
- len_err  out  1  invalid rate or length; qualified by done

## Operation

- N_DBPS lookup on the latched rate:
  - Non-HT codes: 1011→24, 1111→36, 1010→48, 1110→72, 1001→96, 1101→144, 1000→192, 1100→216.
  - HT MCS0-7: 26, 52, 78, 104, 156, 208, 234, 260.
  - Any other code gives 0, which means invalid.
- FSM states: IDLE → LOAD → DIV → FINAL → DONE → IDLE.
- IDLE: on start=1, latch psdu_len and pkt_rate, then go to LOAD. Start in any other state is ignored.
- LOAD:
  - Set rem = 22 + 8*psdu_len (20 bits; 16 SERVICE + 6 tail bits) and cnt = 1.
  - Register N_DBPS.
  - If N_DBPS = 0, or non-HT with psdu_len > 4095: set len_err=1, zero all numeric outputs, and go directly to DONE.
- DIV, one comparison per cycle:
  - If rem ≤ N_DBPS: n_ofdm_sym = cnt, n_pad_bits = N_DBPS − rem, go to FINAL.
  - Otherwise: rem −= N_DBPS, cnt += 1.
- FINAL:
  - Non-HT: tx_duration_us = 20 + 4*n_ofdm_sym; l_sig_len = psdu_len.
  - HT mixed format: tx_duration_us = 36 + 4*n_ofdm_sym; spoof length = 3*n_ofdm_sym + 9 (17-bit intermediate).
    - If spoof > 4095: len_err=1 and l_sig_len = 4095. All other outputs stay computed.
    - Otherwise: l_sig_len = spoof.
- DONE: done=1 for one cycle, then return to IDLE.
- Outputs hold their values until the next LOAD. LOAD clears len_err.
- Exact multiple (rem == N_DBPS in DIV) gives n_pad_bits = 0 with no extra symbol.
- psdu_len = 0 is valid: 22 bits, one symbol.

## Timing

- Reset values: busy=0, done=0, n_ofdm_sym=0, n_pad_bits=0, tx_duration_us=0, l_sig_len=0, len_err=0, state=IDLE.
- Reset applies immediately and asynchronously, including in the middle of DIV. The in-flight request is discarded.
- Valid request: start sampled at edge E0.
  - busy is high from E0 until the edge at which DONE is entered.
  - done is high for exactly the cycle after edge E0 + n_ofdm_sym + 2.
  - Total latency is n_ofdm_sym + 3 cycles.
- Error detected in LOAD: done is high in the cycle after E0+1. Latency is 2 cycles.
- Worst case is HT MCS0 with 65535 bytes: 20169 cycles.
- enable=0 stretches all state durations by the number of low cycles. It never drops or duplicates a done pulse.
- A new start is accepted in the first IDLE cycle after done, so back-to-back requests have zero bubble.

## Test plan

- Non-HT 6 Mbps, pkt_rate=0x0B, psdu_len=100 → n_ofdm_sym=35, n_pad_bits=18, tx_duration_us=160, l_sig_len=100, len_err=0; done 38 cycles after start.
- HT MCS7, pkt_rate=0x87, psdu_len=1500 → n_ofdm_sym=47, n_pad_bits=198, tx_duration_us=224, l_sig_len=150, len_err=0.
- Boundary sizes:
  - HT MCS0, len=7 → sym=3, pad=0 (exact multiple).
  - Non-HT 54 Mbps (0x0C), len=0 → sym=1, pad=194, dur=24, l_sig_len=0, latency 4.
- Errors:
  - pkt_rate=0x05 → len_err=1, all numeric outputs 0, done 2 cycles after start.
  - 0x0B with len=4096 → same.
  - HT MCS0, len=65535 → sym=20166, pad=14, dur=80700, l_sig_len=4095, len_err=1.
- Control:
  - start pulsed during DIV is ignored, and the results match the first request.
  - enable held low 10 cycles mid-DIV → done delayed by exactly 10 cycles.
  - reset asserted mid-DIV → busy=0 and all outputs 0 before the next edge; a fresh request then completes correctly.
